// File: rtl/distcalc_seq.sv
// Sequencer for the Euclidean distance datapath: streams a vector pair chunk by chunk through the
// pipe/accumulate/sqrt stages and returns one registered distance (or timeout) per start pulse.
module distcalc_seq #(
  parameter int unsigned VARWIDTH  = 32,
  parameter int unsigned PIPEWIDTH = 16,
  parameter int unsigned CNTW      = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CNTW-1:0]               nchunks,
  output logic                          chunk_req,
  output logic [CNTW-1:0]               chunk_idx,
  input  logic                          chunk_vld,
  input  logic [VARWIDTH*PIPEWIDTH-1:0] vec0_in,
  input  logic [VARWIDTH*PIPEWIDTH-1:0] vec1_in,
  output logic                          EN_Pipe,
  output logic                          EN_Acc,
  output logic                          EN_Sqrt,
  output logic                          RST_Acc,
  output logic                          RST_Sqrt,
  output logic                          PRE_Acc,
  output logic [VARWIDTH*PIPEWIDTH-1:0] invec0,
  output logic [VARWIDTH*PIPEWIDTH-1:0] invec1,
  input  logic                          RDY_Acc,
  input  logic                          RDY_Sqrt,
  input  logic [VARWIDTH-1:0]           outval,
  output logic                          busy,
  output logic                          done,
  output logic [VARWIDTH-1:0]           dist_out,
  output logic                          err
);

  localparam int unsigned VecW = VARWIDTH * PIPEWIDTH;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TimeoutVal = TmrW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StPipe, StAcc, StSqrt, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     n_q, n_d;
  logic [CNTW-1:0]     idx_q, idx_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [VecW-1:0]     invec0_q, invec0_d;
  logic [VecW-1:0]     invec1_q, invec1_d;
  logic [VARWIDTH-1:0] dist_q, dist_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      invec0_q <= '0;
      invec1_q <= '0;
      dist_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      invec0_q <= invec0_d;
      invec1_q <= invec1_d;
      dist_q   <= dist_d;
      err_q    <= err_d;
    end
  end

  // Timer defaults to zero so every ACC/SQRT entry starts a fresh wait window.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    timer_d  = '0;
    invec0_d = invec0_q;
    invec1_d = invec1_q;
    dist_d   = dist_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (nchunks != '0) begin
            n_d     = nchunks;
            state_d = StClear;
          end else begin
            dist_d  = '0;
            state_d = StDone;
          end
        end
      end
      StClear: begin
        idx_d   = '0;
        state_d = StFetch;
      end
      StFetch: begin
        if (chunk_vld) begin
          invec0_d = vec0_in;
          invec1_d = vec1_in;
          state_d  = StPipe;
        end
      end
      StPipe: state_d = StAcc;
      StAcc: begin
        // A ready arriving on the expiry cycle still counts as success.
        if (RDY_Acc) begin
          if (idx_q == n_q - CNTW'(1)) begin
            state_d = StSqrt;
          end else begin
            idx_d   = idx_q + CNTW'(1);
            state_d = StFetch;
          end
        end else if (timer_q == TimeoutVal) begin
          err_d   = 1'b1;
          dist_d  = '1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StSqrt: begin
        if (RDY_Sqrt) begin
          dist_d  = outval;
          state_d = StDone;
        end else if (timer_q == TimeoutVal) begin
          err_d   = 1'b1;
          dist_d  = '1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign chunk_req = (state_q == StFetch);
  assign chunk_idx = idx_q;
  assign EN_Pipe   = (state_q == StPipe) || (state_q == StAcc);
  assign EN_Acc    = (state_q == StAcc);
  assign EN_Sqrt   = (state_q == StSqrt);
  assign RST_Acc   = (state_q == StClear);
  assign RST_Sqrt  = (state_q == StClear);
  assign PRE_Acc   = (state_q == StAcc) && (idx_q != '0);
  assign invec0    = invec0_q;
  assign invec1    = invec1_q;
  assign dist_out  = dist_q;
  assign err       = err_q;

endmodule

// File: tb/tb_distcalc_seq.sv
// Bench for distcalc_seq: a responsive source/datapath stand-in driven by per-chunk wait plans,
// checked against a transaction-level model of chunk order, latency, PRE_Acc and results.
module tb_distcalc_seq;

  localparam int unsigned VW   = 32;
  localparam int unsigned PW   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned TO   = 255;
  localparam int unsigned VecW = VW * PW;
  localparam int          Never = 1000;

  logic            clk, rst_n, start, chunk_vld, RDY_Acc, RDY_Sqrt;
  logic [CW-1:0]   nchunks, chunk_idx;
  logic [VecW-1:0] vec0_in, vec1_in, invec0, invec1;
  logic            chunk_req, EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc;
  logic [VW-1:0]   outval, dist_out;
  logic            busy, done, err;

  distcalc_seq #(.VARWIDTH(VW), .PIPEWIDTH(PW), .CNTW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nchunks(nchunks),
    .chunk_req(chunk_req), .chunk_idx(chunk_idx), .chunk_vld(chunk_vld),
    .vec0_in(vec0_in), .vec1_in(vec1_in),
    .EN_Pipe(EN_Pipe), .EN_Acc(EN_Acc), .EN_Sqrt(EN_Sqrt),
    .RST_Acc(RST_Acc), .RST_Sqrt(RST_Sqrt), .PRE_Acc(PRE_Acc),
    .invec0(invec0), .invec1(invec1), .RDY_Acc(RDY_Acc), .RDY_Sqrt(RDY_Sqrt),
    .outval(outval), .busy(busy), .done(done), .dist_out(dist_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-run plan: cycles before chunk_vld / RDY_Acc per chunk, cycles before RDY_Sqrt.
  int              fw[16];
  int              aw[16];
  int              sw;
  logic [VW-1:0]   outv;
  logic [VecW-1:0] d0[16];
  logic [VecW-1:0] d1[16];

  task automatic chk(input string tag, input logic [VecW-1:0] got, input logic [VecW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_vec(output logic [VecW-1:0] v);
    for (int i = 0; i < int'(PW); i++) v[i*VW +: VW] = $urandom;
  endtask

  task automatic plan_random(input int maxw);
    for (int k = 0; k < 16; k++) begin
      fw[k] = $urandom_range(0, maxw);
      aw[k] = $urandom_range(0, maxw);
      rand_vec(d0[k]);
      rand_vec(d1[k]);
    end
    sw   = $urandom_range(0, maxw);
    outv = $urandom;
  endtask

  // Model: cycles from start acceptance to done, chunks fetched, and the error outcome.
  function automatic int model(input int n, output int nfetch, output logic xerr);
    int t;
    nfetch = 0;
    xerr   = 1'b0;
    if (n == 0) return 1;
    t = 2;
    for (int k = 0; k < n; k++) begin
      nfetch++;
      t += fw[k] + 2;
      if (aw[k] > int'(TO)) begin
        xerr = 1'b1;
        return t + int'(TO) + 1;
      end
      t += aw[k] + 1;
    end
    if (sw > int'(TO)) begin
      xerr = 1'b1;
      return t + int'(TO) + 1;
    end
    return t + sw + 1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, VecW'(busy), '0);
    chk({tag, "_done"}, VecW'(done), '0);
    chk({tag, "_ctl"}, VecW'({chunk_req, EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc}),
        '0);
    chk({tag, "_idx"}, VecW'(chunk_idx), '0);
    chk({tag, "_invec0"}, invec0, '0);
    chk({tag, "_invec1"}, invec1, '0);
    chk({tag, "_dist"}, VecW'(dist_out), '0);
    chk({tag, "_err"}, VecW'(err), '0);
  endtask

  task automatic run_txn(input string tag, input int n, input bit extra);
    int   exp_lat, nfetch, cyc, limit, done_cyc, ndone, nclr, nact, fcnt, acnt, scnt, kf, ka;
    logic xerr, prev_acc;
    logic [VW-1:0] xdist, held;
    int   idx_obs[$];
    logic pre_obs[$];
    exp_lat = model(n, nfetch, xerr);
    xdist   = xerr ? '1 : ((n == 0) ? '0 : outv);
    limit   = exp_lat + 20;
    {done_cyc, ndone, nclr, nact, fcnt, acnt, scnt, kf, ka} = '0;
    prev_acc = 1'b0;
    held     = '0;
    @(negedge clk);
    start   = 1'b1;
    nchunks = CW'(n);
    cyc     = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          held     = dist_out;
          chk({tag, "_dist"}, VecW'(dist_out), VecW'(xdist));
          chk({tag, "_err"}, VecW'(err), VecW'(xerr));
        end
      end
      if (RST_Acc) nclr++;
      if (RST_Acc !== RST_Sqrt) chk({tag, "_rstsqrt"}, VecW'(RST_Sqrt), VecW'(RST_Acc));
      if (chunk_req || EN_Pipe || EN_Acc || EN_Sqrt) nact++;
      if (EN_Acc && !prev_acc) begin
        pre_obs.push_back(PRE_Acc);
        if (ka < 16) begin
          chk($sformatf("%s_invec0_c%0d", tag, ka), invec0, d0[ka]);
          chk($sformatf("%s_invec1_c%0d", tag, ka), invec1, d1[ka]);
        end
      end
      prev_acc = EN_Acc;
      // Source model
      rand_vec(vec0_in);
      rand_vec(vec1_in);
      if (chunk_req) begin
        chunk_vld = (kf < 16) && (fcnt == fw[kf]);
        fcnt++;
        if (chunk_vld) begin
          vec0_in = d0[kf];
          vec1_in = d1[kf];
          idx_obs.push_back(int'(chunk_idx));
          kf++;
          fcnt = 0;
        end
      end else begin
        chunk_vld = 1'($urandom_range(0, 1));
        fcnt      = 0;
      end
      // Datapath model
      RDY_Acc = EN_Acc && (ka < 16) && (acnt == aw[ka]);
      if (RDY_Acc) begin
        ka++;
        acnt = 0;
      end else acnt = EN_Acc ? acnt + 1 : 0;
      RDY_Sqrt = EN_Sqrt && (scnt == sw);
      scnt     = EN_Sqrt ? scnt + 1 : 0;
      outval   = RDY_Sqrt ? outv : VW'($urandom);
      if (extra && busy && (cyc % 5 == 2)) begin
        start   = 1'b1;
        nchunks = CW'($urandom);
      end
      if (ndone != 0 && cyc >= done_cyc + 3) break;
      if (cyc >= limit) break;
    end
    start     = 1'b0;
    chunk_vld = 1'b0;
    RDY_Acc   = 1'b0;
    RDY_Sqrt  = 1'b0;
    chk({tag, "_ndone"}, VecW'(ndone), 1);
    chk({tag, "_latency"}, VecW'(done_cyc), VecW'(exp_lat));
    chk({tag, "_held"}, VecW'(dist_out), VecW'(held));
    chk({tag, "_idle"}, VecW'(busy), '0);
    chk({tag, "_nclr"}, VecW'(nclr), VecW'(n != 0));
    if (n == 0) chk({tag, "_noact"}, VecW'(nact), '0);
    chk({tag, "_nidx"}, VecW'(idx_obs.size()), VecW'(nfetch));
    for (int k = 0; k < nfetch && k < idx_obs.size(); k++)
      chk($sformatf("%s_idx%0d", tag, k), VecW'(idx_obs[k]), VecW'(k));
    chk({tag, "_npre"}, VecW'(pre_obs.size()), VecW'(nfetch));
    for (int k = 0; k < nfetch && k < pre_obs.size(); k++)
      chk($sformatf("%s_pre%0d", tag, k), VecW'(pre_obs[k]), VecW'(k != 0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    nchunks   = '0;
    chunk_vld = 1'b0;
    vec0_in   = '0;
    vec1_in   = '0;
    RDY_Acc   = 1'b0;
    RDY_Sqrt  = 1'b0;
    outval    = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Single chunk, all lanes 3 against 0, ready after two cycles.
    plan_random(3);
    for (int i = 0; i < int'(PW); i++) d0[0][i*VW +: VW] = 3;
    d1[0] = '0;
    aw[0] = 2;
    sw    = 2;
    outv  = 12;
    run_txn("one_chunk", 1, 1'b0);

    plan_random(3);
    fw[0] = 0; fw[1] = 5; fw[2] = 1;
    run_txn("three_chunk", 3, 1'b0);

    plan_random(2);
    sw = Never;
    run_txn("sqrt_timeout", 1, 1'b0);

    run_txn("zero_chunks", 0, 1'b0);

    plan_random(2);
    sw = int'(TO);
    run_txn("sqrt_rdy_at_expiry", 2, 1'b0);

    plan_random(2);
    aw[1] = Never;
    run_txn("acc_timeout", 3, 1'b0);

    plan_random(2);
    run_txn("extra_starts", 2, 1'b1);

    // Reset while accumulating: immediate abort, outputs back to zero, no done.
    @(negedge clk);
    start     = 1'b1;
    nchunks   = 4'd2;
    chunk_vld = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (EN_Acc) break;
    end
    chk("reached_acc", VecW'(EN_Acc), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    chunk_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset_nodone", VecW'({busy, done}), '0);
    rst_n = 1'b1;
    plan_random(2);
    run_txn("after_reset", 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      plan_random(3);
      run_txn($sformatf("rand%0d", r), $urandom_range(1, 15), 1'(r & 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
